// File: rtl/gray_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gray_counter
//  Description : Up/down binary counter with registered Gray-code mirror,
//                wrap or saturate at the ends, plus a 2-stage Gray/binary
//                converter pipeline that runs independently of the counter.
//  Revision    : 1.0  initial release
// ============================================================================
module gray_counter #(
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc,
    input  logic             conv_valid_in,
    input  logic             conv_mode,
    input  logic [WIDTH-1:0] conv_in,
    output logic             conv_valid_out,
    output logic [WIDTH-1:0] conv_out
);

    localparam logic [WIDTH-1:0] c_max  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_zero = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_tc;
    logic [WIDTH-1:0] w_next_bin;
    logic             w_next_tc;

    // A blocked (saturating) or wrapping step both raise the terminal pulse.
    always_comb begin
        w_next_bin = r_bin;
        w_next_tc  = 1'b0;
        if (load) begin
            w_next_bin = load_val;
        end else if (en) begin
            if (up) begin
                if (r_bin == c_max) begin
                    w_next_tc  = 1'b1;
                    w_next_bin = (SATURATE != 0) ? r_bin : c_zero;
                end else begin
                    w_next_bin = r_bin + c_one;
                end
            end else begin
                if (r_bin == c_zero) begin
                    w_next_tc  = 1'b1;
                    w_next_bin = (SATURATE != 0) ? r_bin : c_max;
                end else begin
                    w_next_bin = r_bin - c_one;
                end
            end
        end
    end

    // Gray is encoded from the next binary value so both registers stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= c_zero;
            r_gray <= c_zero;
            r_tc   <= 1'b0;
        end else begin
            r_bin  <= w_next_bin;
            r_gray <= w_next_bin ^ (w_next_bin >> 1);
            r_tc   <= w_next_tc;
        end
    end

    assign bin_out  = r_bin;
    assign gray_out = r_gray;
    assign tc       = r_tc;

    // ------------------------------------------------------------------------
    // Converter pipeline: stage 1 captures operand/mode, stage 2 holds result.
    // ------------------------------------------------------------------------
    logic             r_s1_valid;
    logic             r_s1_mode;
    logic [WIDTH-1:0] r_s1_data;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;
    logic [WIDTH-1:0] w_b2g;
    logic [WIDTH-1:0] w_g2b;
    logic [WIDTH-1:0] w_conv_result;

    assign w_b2g = r_s1_data ^ (r_s1_data >> 1);

    assign w_g2b[WIDTH-1] = r_s1_data[WIDTH-1];
    generate
        for (genvar gi = WIDTH - 2; gi >= 0; gi--) begin : g_g2b
            assign w_g2b[gi] = w_g2b[gi+1] ^ r_s1_data[gi];
        end
    endgenerate

    assign w_conv_result = r_s1_mode ? w_g2b : w_b2g;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_data  <= c_zero;
            r_s2_valid <= 1'b0;
            r_s2_data  <= c_zero;
        end else begin
            r_s1_valid <= conv_valid_in;
            if (conv_valid_in) begin
                r_s1_mode <= conv_mode;
                r_s1_data <= conv_in;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_conv_result;
            end
        end
    end

    assign conv_valid_out = r_s2_valid;
    assign conv_out       = r_s2_data;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_gray_counter
//  Description : Directed bench for gray_counter, wrap (dut0) and saturate
//                (dut1) variants driven side by side, WIDTH=4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gray_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic       conv_valid_in;
    logic       conv_mode;
    logic [3:0] conv_in;

    logic [3:0] bin0, gray0, cout0;
    logic       tc0, cvo0;
    logic [3:0] bin1, gray1, cout1;
    logic       tc1, cvo1;

    int checks   = 0;
    int failures = 0;

    logic [3:0] gtab [0:15] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};
    logic [3:0] prev_gray;

    gray_counter #(.WIDTH(4), .SATURATE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .bin_out(bin0), .gray_out(gray0), .tc(tc0),
        .conv_valid_in(conv_valid_in), .conv_mode(conv_mode),
        .conv_in(conv_in), .conv_valid_out(cvo0), .conv_out(cout0)
    );

    gray_counter #(.WIDTH(4), .SATURATE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .bin_out(bin1), .gray_out(gray1), .tc(tc1),
        .conv_valid_in(conv_valid_in), .conv_mode(conv_mode),
        .conv_in(conv_in), .conv_valid_out(cvo1), .conv_out(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bin0"}, 32'(bin0), 0);
        chk({tag, "_gray0"}, 32'(gray0), 0);
        chk({tag, "_tc0"}, 32'(tc0), 0);
        chk({tag, "_cvo0"}, 32'(cvo0), 0);
        chk({tag, "_cout0"}, 32'(cout0), 0);
        chk({tag, "_bin1"}, 32'(bin1), 0);
        chk({tag, "_cvo1"}, 32'(cvo1), 0);
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 4'h0;
        conv_valid_in = 1'b0; conv_mode = 1'b0; conv_in = 4'h0;
        step();
        step();

        // Reset asserted between edges must clear outputs immediately.
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("reset_async");
        step();
        rst_n = 1'b1;
        chk_all_zero("reset_state");

        // Count up 16 steps: full Gray sequence, wrap with tc on dut0.
        en = 1'b1; up = 1'b1;
        prev_gray = gray0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("up_gray_%0d", i), 32'(gray0), 32'(gtab[i % 16]));
            chk($sformatf("up_bin_%0d", i), 32'(bin0), 32'(i % 16));
            chk($sformatf("up_tc_%0d", i), 32'(tc0), (i == 16) ? 1 : 0);
            chk($sformatf("up_onebit_%0d", i), $countones(gray0 ^ prev_gray), 1);
            prev_gray = gray0;
        end
        chk("sat_up_bin", 32'(bin1), 32'hF);
        chk("sat_up_gray", 32'(gray1), 32'h8);
        chk("sat_up_tc", 32'(tc1), 1);

        step();
        chk("after_wrap_bin", 32'(bin0), 1);
        chk("after_wrap_tc", 32'(tc0), 0);
        chk("sat_blocked_again_tc", 32'(tc1), 1);

        // Load zero into both, then decrement from zero.
        load = 1'b1; load_val = 4'h0;
        step();
        chk("load0_bin0", 32'(bin0), 0);
        chk("load0_bin1", 32'(bin1), 0);
        chk("load0_tc1", 32'(tc1), 0);
        load = 1'b0; up = 1'b0;
        step();
        chk("down_wrap_bin", 32'(bin0), 32'hF);
        chk("down_wrap_gray", 32'(gray0), 32'h8);
        chk("down_wrap_tc", 32'(tc0), 1);
        chk("sat_down_bin", 32'(bin1), 0);
        chk("sat_down_gray", 32'(gray1), 0);
        chk("sat_down_tc", 32'(tc1), 1);

        step();
        chk("down_step_bin", 32'(bin0), 32'hE);
        chk("down_step_gray", 32'(gray0), 32'h9);
        chk("down_step_tc", 32'(tc0), 0);

        en = 1'b0;
        step();
        chk("hold_bin", 32'(bin0), 32'hE);
        chk("hold_gray", 32'(gray0), 32'h9);

        // Load wins over en/up in the same cycle.
        load = 1'b1; load_val = 4'b1010; en = 1'b1; up = 1'b1;
        step();
        chk("load_bin", 32'(bin0), 32'hA);
        chk("load_gray", 32'(gray0), 32'hF);
        chk("load_tc", 32'(tc0), 0);
        chk("load_bin_sat", 32'(bin1), 32'hA);
        load = 1'b0; en = 1'b0;

        // Converter: back-to-back operands, 2-cycle latency, hold afterwards.
        conv_valid_in = 1'b1; conv_mode = 1'b1; conv_in = 4'b1101;
        step();
        chk("conv_lat1_valid", 32'(cvo0), 0);
        conv_mode = 1'b0; conv_in = 4'b0111;
        step();
        chk("conv_g2b_valid", 32'(cvo0), 1);
        chk("conv_g2b_out", 32'(cout0), 32'h9);
        conv_valid_in = 1'b0; conv_mode = 1'b1; conv_in = 4'b1111;
        step();
        chk("conv_b2g_valid", 32'(cvo0), 1);
        chk("conv_b2g_out", 32'(cout0), 32'h4);
        step();
        chk("conv_idle_valid", 32'(cvo0), 0);
        chk("conv_hold_out", 32'(cout0), 32'h4);
        step();
        chk("conv_invalid_op_valid", 32'(cvo0), 0);
        chk("conv_invalid_op_out", 32'(cout0), 32'h4);

        // Reset one cycle after an operand enters: it must vanish.
        conv_valid_in = 1'b1; conv_mode = 1'b0; conv_in = 4'b0011;
        step();
        conv_valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("flight_rst_async");
        step();
        chk_all_zero("flight_rst_edge");
        rst_n = 1'b1;
        step();
        chk_all_zero("flight_post1");
        step();
        chk_all_zero("flight_post2");

        // First step after reset starts from zero.
        en = 1'b1; up = 1'b1;
        step();
        chk("post_rst_bin", 32'(bin0), 1);
        chk("post_rst_gray", 32'(gray0), 1);
        en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
